// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline hazard controller: FSM state encoding,
// forwarding-override codes and the default redirect length.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_REDIRECT   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    LU_NONE  = 2'b00,
    LU_MEMWB = 2'b01
  } load_use_t;

  localparam int unsigned REDIRECT_CYCLES_DEF = 2;
  localparam int unsigned CNT_W               = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Combinational load-use comparator: flags which ID source operand depends on the
// load currently in EX. Register 0 never creates a dependency.
module hazard_cmp (
  input  logic       ex_load_signal,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       match_rs,
  output logic       match_rt,
  output logic       hazard
);

  logic load_live;

  assign load_live = ex_load_signal && (ex_rt != 5'd0);
  assign match_rs  = load_live && id_uses_rs && (id_rs == ex_rt);
  assign match_rt  = load_live && id_uses_rt && (id_rt == ex_rt);
  assign hazard    = match_rs || match_rt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall and branch/jump flush controller for a 5-stage pipeline.
// Optional HAZARD_STATS_EN adds saturating stall_count/flush_count outputs.
//
// state         | meaning
// ST_IDLE       | no hazard in progress; detects redirect / load-use combinationally
// ST_LOAD_STALL | one bubble cycle after a load-use stall; forward load data to ID
// ST_REDIRECT   | flushing wrong-path instructions while the counter runs down
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned REDIRECT_CYCLES = REDIRECT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_load_signal,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic [1:0] ex_jump,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] load_useA,
  output logic [1:0] load_useB,
  output logic       busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
`endif
);

  // The redirect cycle itself is the first flushed cycle, so REDIRECT holds for
  // RELOAD more cycles; with REDIRECT_CYCLES==1 the FSM never leaves IDLE.
  localparam logic [CNT_W-1:0] RELOAD      = CNT_W'(REDIRECT_CYCLES - 1);
  localparam state_t           REDIR_STATE = (RELOAD == '0) ? ST_IDLE : ST_REDIRECT;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             match_a_q;
  logic             match_b_q;

  logic match_rs;
  logic match_rt;
  logic hazard;
  logic redirect;
  logic take_redirect;
  logic take_stall;

  hazard_cmp u_cmp (
    .ex_load_signal (ex_load_signal),
    .ex_rt          (ex_rt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .match_rs       (match_rs),
    .match_rt       (match_rt),
    .hazard         (hazard)
  );

  assign redirect = ex_branch_taken || (ex_jump != 2'b00);

  always_comb begin
    take_redirect = 1'b0;
    take_stall    = 1'b0;
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    load_useA     = LU_NONE;
    load_useB     = LU_NONE;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          take_redirect = 1'b1;
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
        end else if (hazard) begin
          take_stall = 1'b1;
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end
      ST_LOAD_STALL: begin
        load_useA = match_a_q ? LU_MEMWB : LU_NONE;
        load_useB = match_b_q ? LU_MEMWB : LU_NONE;
        if (redirect) begin
          take_redirect = 1'b1;
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
        end
      end
      ST_REDIRECT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      take_redirect = 1'b0;
      take_stall    = 1'b0;
      pc_stall      = 1'b0;
      ifid_stall    = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      load_useA     = LU_NONE;
      load_useB     = LU_NONE;
    end
  end

  assign busy = !rst && (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      match_a_q <= 1'b0;
      match_b_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take_redirect) begin
            cnt_q   <= RELOAD;
            state_q <= REDIR_STATE;
          end else if (take_stall) begin
            match_a_q <= match_rs;
            match_b_q <= match_rt;
            state_q   <= ST_LOAD_STALL;
          end
        end
        ST_LOAD_STALL: begin
          match_a_q <= 1'b0;
          match_b_q <= 1'b0;
          if (take_redirect) begin
            cnt_q   <= RELOAD;
            state_q <= REDIR_STATE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REDIRECT: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // One increment per event: a redirect counts once however many cycles it flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (take_stall)    stall_cnt_q <= sat_inc16(stall_cnt_q);
      if (take_redirect) flush_cnt_q <= sat_inc16(flush_cnt_q);
    end
  end

  assign stall_count = rst ? 16'd0 : stall_cnt_q;
  assign flush_count = rst ? 16'd0 : flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes hand-computed output
// vectors; a negedge monitor pops and compares. Stats checks need HAZARD_STATS_EN.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic       ex_load_signal = 1'b0, ex_branch_taken = 1'b0;
  logic [1:0] ex_jump = '0;
  logic       pc_stall, ifid_stall, ifid_flush, idex_flush, busy;
  logic [1:0] load_useA, load_useB;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count, flush_count;
`endif

  pipeline_hazard_ctrl #(.REDIRECT_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_load_signal  (ex_load_signal),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .ex_jump         (ex_jump),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .load_useA       (load_useA),
    .load_useB       (load_useB),
    .busy            (busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  always #5 clk = ~clk;

  // {pc_stall, ifid_stall, ifid_flush, idex_flush, load_useA, load_useB, busy}
  localparam logic [8:0] E_ZERO    = 9'b0000_0000_0;
  localparam logic [8:0] E_STALL   = 9'b1101_0000_0;
  localparam logic [8:0] E_LS_A    = 9'b0000_0100_1;
  localparam logic [8:0] E_LS_B    = 9'b0000_0001_1;
  localparam logic [8:0] E_LS_AB   = 9'b0000_0101_1;
  localparam logic [8:0] E_FL0     = 9'b0011_0000_0;
  localparam logic [8:0] E_FL1     = 9'b0011_0000_1;
  localparam logic [8:0] E_LS_A_FL = 9'b0011_0100_1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q[$];
  string      name_q[$];

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, {7'd0, pc_stall, ifid_stall, ifid_flush, idex_flush, load_useA, load_useB, busy},
            {7'd0, e});
    end
  end

  task automatic step(input string nm, input logic r, input logic br, input logic [1:0] jp,
                      input logic ld, input logic [4:0] ert, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urs, input logic urt,
                      input logic [8:0] exp);
    @(posedge clk);
    #1;
    rst = r; ex_branch_taken = br; ex_jump = jp; ex_load_signal = ld; ex_rt = ert;
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm, input logic [8:0] exp);
    step(nm, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, exp);
  endtask

`ifdef HAZARD_STATS_EN
  logic [15:0] sc0, fc0;
`endif

  initial begin
    // reset masks a live load-use hazard
    step("reset_masks", 1'b1, 1'b0, 2'b00, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, E_ZERO);
    idle("post_reset", E_ZERO);

    step("lu_rs_c0", 1'b0, 1'b0, 2'b00, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, E_STALL);
    idle("lu_rs_c1", E_LS_A);
    idle("lu_rs_c2", E_ZERO);

    step("lu_rt_c0", 1'b0, 1'b0, 2'b00, 1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b1, E_STALL);
    idle("lu_rt_c1", E_LS_B);

    step("lu_both_c0", 1'b0, 1'b0, 2'b00, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, E_STALL);
    idle("lu_both_c1", E_LS_AB);
    idle("lu_both_c2", E_ZERO);

    step("unused_rs", 1'b0, 1'b0, 2'b00, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, E_ZERO);
    step("no_load", 1'b0, 1'b0, 2'b00, 1'b0, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, E_ZERO);
    step("rt_zero", 1'b0, 1'b0, 2'b00, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, E_ZERO);

    // taken branch; a load-use in the squashed REDIRECT cycle is ignored
    step("br_c0", 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_FL0);
    step("br_c1_ign", 1'b0, 1'b0, 2'b00, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, E_FL1);
    idle("br_c2", E_ZERO);

`ifdef HAZARD_STATS_EN
    @(negedge clk);
    sc0 = stall_count;
    fc0 = flush_count;
`endif
    step("simul_c0", 1'b0, 1'b0, 2'b01, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, E_FL0);
    idle("simul_c1", E_FL1);
    idle("simul_c2", E_ZERO);
`ifdef HAZARD_STATS_EN
    @(negedge clk);
    check("simul_flush_cnt", flush_count, fc0 + 16'd1);
    check("simul_stall_cnt", stall_count, sc0);
`endif

    // redirect during LOAD_STALL wins
    step("lsr_c0", 1'b0, 1'b0, 2'b00, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, E_STALL);
    step("lsr_c1", 1'b0, 1'b0, 2'b10, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_LS_A_FL);
    idle("lsr_c2", E_FL1);
    idle("lsr_c3", E_ZERO);

    // reset during the REDIRECT cycle
    step("rst_br_c0", 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_FL0);
    step("rst_br_c1", 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_ZERO);
    idle("rst_br_c2", E_ZERO);

    // reset during LOAD_STALL
    step("rst_ls_c0", 1'b0, 1'b0, 2'b00, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, E_STALL);
    step("rst_ls_c1", 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_ZERO);
    idle("rst_ls_c2", E_ZERO);

`ifdef HAZARD_STATS_EN
    @(negedge clk);
    check("stats_reset", stall_count, 16'd0);
    dut.stall_cnt_q = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      step("sat_stall", 1'b0, 1'b0, 2'b00, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, E_STALL);
      idle("sat_ls", E_LS_A);
    end
    idle("sat_idle", E_ZERO);
    @(negedge clk);
    check("stall_saturate", stall_count, 16'hFFFF);
`endif

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
